lcd_string_writer: RTL and testbench
====================================

# lcd_string_writer

Display back end for the number-guess game: takes the 16-character ASCII message that the game core produces on its `string` bus and writes it to row 0 of an HD44780-compatible character LCD over an 8-bit parallel, write-only interface. On reset it runs the LCD power-on initialisation. After that, each refresh request copies the current string and transfers it as one address command followed by 16 data bytes. All LCD timing comes from cycle counts, so the block works at any clock frequency once the parameters are set for it.

## Interface
Parameters:
- `INIT_WAIT`, default 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- `E_PULSE`, default 12: cycles that `lcd_e` stays high for each byte.
- `CMD_WAIT`, default 2500: idle cycles after each byte (50 µs).
- `CLEAR_WAIT`, default 82000: idle cycles after the clear command 0x01, used instead of `CMD_WAIT`.

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `reset`, input, 1: reset, asynchronous and active-low.
- `string`, input, 128 (`[16*8:1]`): message; `string[128:121]` is character 0 (leftmost).
- `update`, input, 1: refresh request, active-high, sampled every cycle.
- `busy`, output, 1: high during initialisation and during a refresh.
- `lcd_rs`, output, 1: 0 for a command byte, 1 for a data byte.
- `lcd_rw`, output, 1: tied to 0.
- `lcd_e`, output, 1: LCD enable strobe.
- `lcd_data`, output, 8: byte on the LCD data bus.

## Operation
Byte write. Each byte goes through three phases:
- SETUP: 1 cycle; `lcd_rs` and `lcd_data` are valid and `lcd_e`=0.
- PULSE: `E_PULSE` cycles with `lcd_e`=1.
- HOLD: `CMD_WAIT` cycles (or `CLEAR_WAIT` after 0x01) with `lcd_e`=0.
- `lcd_rs` and `lcd_data` stay constant from SETUP through the end of HOLD.

Top-level states:
- INIT_DLY: counts `INIT_WAIT` cycles.
- INIT_CMD: writes 0x38, 0x0C, 0x06, 0x01 in that order, then goes to IDLE.
- IDLE: waits for a refresh request.
- ADDR: writes command 0x80.
- CHAR: writes data bytes for characters 0 to 15, then returns to IDLE.

Refresh behaviour:
- The string is copied into an internal snapshot in the cycle that IDLE leaves for ADDR. Changes to `string` after that point do not affect the transfer in progress.
- A character byte of 0x00 is sent as 0x20 (space), so short messages padded with zeros display as blanks. All other bytes are sent unchanged.
- `update` asserted during INIT_DLY, INIT_CMD, ADDR or CHAR sets a one-deep `pending` flag. When the block returns to IDLE with `pending` set, it clears the flag and starts a new refresh on the next cycle, copying the string as it is at that point. Several requests while busy collapse into one.
- `update` held high in IDLE starts one refresh; if it is still high when that refresh ends, it triggers another.
- `busy` is high in every state except IDLE. It drops in the same cycle that IDLE is entered.

## Timing
Reset values, with `reset` low (asynchronous):
- State is INIT_DLY with the counter at 0, and `pending`=0.
- `busy`=1, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00.

Reset asserted mid-byte: `lcd_e` drops immediately and the whole initialisation sequence repeats after release.

Cycle counts:
- One byte takes exactly 1 + `E_PULSE` + `CMD_WAIT` cycles (the clear command uses `CLEAR_WAIT`).
- Initialisation from reset release to IDLE takes `INIT_WAIT` + 4 + 4·`E_PULSE` + 3·`CMD_WAIT` + `CLEAR_WAIT` cycles.
- A refresh takes 17·(1 + `E_PULSE` + `CMD_WAIT`) cycles.
- Latency from `update` sampled high in IDLE to the first SETUP cycle is 1 cycle.

Counter width is `$clog2` of the largest parameter plus 1. Counters saturate and never wrap.

## Configuration
`LCD_AUTO_REFRESH_EN`:
- Defined: the block also compares `string` with the last copied snapshot every cycle. A mismatch is treated exactly like `update`=1, so the display follows the game core without a separate strobe. Until the first refresh the snapshot compares as all-0xFF, so the first string always triggers one refresh.
- Not defined: refreshes happen only on `update`, and the comparison logic is not built.

## Test plan
Bench parameters: `INIT_WAIT`=10, `E_PULSE`=2, `CMD_WAIT`=3, `CLEAR_WAIT`=20.

- Release `reset` at t0. Required: `busy`=1 throughout. The first SETUP comes 10 cycles later with `lcd_data`=0x38 and `lcd_rs`=0. `lcd_e` pulses 2 cycles wide. Bytes 0x38, 0x0C, 0x06, 0x01 appear in that order. `busy` falls exactly 10+4+8+9+20 = 51 cycles after release.
- `string`="YOU WIN! 7 TRIES", one `update` pulse in IDLE. Required: 0x80 with rs=0, then the 16 ASCII bytes with rs=1 starting with 0x59 ('Y'). Each byte takes 6 cycles. `busy` is high for 102 cycles.
- `string` zero-padded (only the low 4 bytes are "LOSE"), then `update`. Required: 12 bytes of 0x20 followed by 0x4C 0x4F 0x53 0x45.
- Three `update` pulses during a refresh, with `string` changed to "TOO HIGH" mid-transfer. Required: the current transfer still sends the old snapshot, then exactly one more refresh sends "TOO HIGH", then IDLE.
- Assert `reset` while `lcd_e`=1 in the middle of CHAR. Required: `lcd_e`=0 and `busy`=1 immediately, and after release the full 0x38 initialisation sequence runs again.
- With `LCD_AUTO_REFRESH_EN` defined, change `string` in IDLE with no `update`. Required: a refresh starts 1 cycle later. Holding `string` constant afterwards produces no further refreshes.

Source files
------------

// File: rtl/lcd_string_writer_if.sv
// Message/refresh request side and HD44780 8-bit write-only pin bundle for lcd_string_writer.
// The message bus is named str because "string" is a reserved word in SystemVerilog.
interface lcd_string_writer_if;
    logic [16*8:1] str;
    logic          update;
    logic          busy;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_e;
    logic [7:0]    lcd_data;

    modport master (
        output str, update,
        input  busy, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    modport slave (
        input  str, update,
        output busy, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface

// File: rtl/lcd_string_writer.sv
// Writes a 16-character message to LCD row 0 after running the HD44780 power-on init.
// Optional: define LCD_AUTO_REFRESH_EN to refresh whenever str differs from the last snapshot.
module lcd_string_writer #(
    parameter int unsigned INIT_WAIT  = 750000,
    parameter int unsigned E_PULSE    = 12,
    parameter int unsigned CMD_WAIT   = 2500,
    parameter int unsigned CLEAR_WAIT = 82000
) (
    input  logic               clk,
    input  logic               reset,
    lcd_string_writer_if.slave bus
);
    localparam int unsigned MAX_A = (INIT_WAIT > E_PULSE) ? INIT_WAIT : E_PULSE;
    localparam int unsigned MAX_B = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_P) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t INIT_LAST  = cnt_t'(INIT_WAIT - 1);
    localparam cnt_t PULSE_LAST = cnt_t'(E_PULSE - 1);
    localparam cnt_t CMD_LAST   = cnt_t'(CMD_WAIT - 1);
    localparam cnt_t CLEAR_LAST = cnt_t'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        S_INIT_DLY,
        S_INIT_CMD,
        S_IDLE,
        S_ADDR,
        S_CHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t        state;
    phase_t        phase;
    cnt_t          cnt;
    cnt_t          cnt_inc;
    cnt_t          hold_last;
    logic [3:0]    idx;
    logic          pending;
    logic          req;
    logic [16*8:1] snap;
    logic          busy_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;

    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Zero bytes become spaces so zero-padded messages show as blanks.
    function automatic logic [7:0] char_at(input logic [16*8:1] s, input logic [3:0] i);
        logic [7:0] c;
        c = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (i == 4'(k)) c = s[8*(16-k) -: 8];
        end
        if (c == 8'h00) c = 8'h20;
        return c;
    endfunction

    always_comb begin
        cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
        hold_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLEAR_LAST : CMD_LAST;
`ifdef LCD_AUTO_REFRESH_EN
        req = bus.update || (bus.str != snap);
`else
        req = bus.update;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT_DLY;
            phase      <= PH_SETUP;
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            snap       <= '1;
            busy_q     <= 1'b1;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            if (state != S_IDLE && req) pending <= 1'b1;

            case (state)
                S_INIT_DLY: begin
                    if (cnt >= INIT_LAST) begin
                        state      <= S_INIT_CMD;
                        phase      <= PH_SETUP;
                        cnt        <= '0;
                        idx        <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= init_cmd(4'd0);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_IDLE: begin
                    if (req || pending) begin
                        pending    <= 1'b0;
                        snap       <= bus.str;
                        state      <= S_ADDR;
                        phase      <= PH_SETUP;
                        cnt        <= '0;
                        busy_q     <= 1'b1;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= 8'h80;
                    end
                end

                // INIT_CMD, ADDR and CHAR share one SETUP/PULSE/HOLD byte engine.
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase   <= PH_PULSE;
                            lcd_e_q <= 1'b1;
                            cnt     <= '0;
                        end

                        PH_PULSE: begin
                            if (cnt >= PULSE_LAST) begin
                                phase   <= PH_HOLD;
                                lcd_e_q <= 1'b0;
                                cnt     <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end

                        default: begin
                            if (cnt >= hold_last) begin
                                phase <= PH_SETUP;
                                cnt   <= '0;
                                case (state)
                                    S_INIT_CMD: begin
                                        if (idx == 4'd3) begin
                                            state  <= S_IDLE;
                                            busy_q <= 1'b0;
                                        end else begin
                                            idx        <= idx + 4'd1;
                                            lcd_data_q <= init_cmd(idx + 4'd1);
                                        end
                                    end
                                    S_ADDR: begin
                                        state      <= S_CHAR;
                                        idx        <= '0;
                                        lcd_rs_q   <= 1'b1;
                                        lcd_data_q <= char_at(snap, 4'd0);
                                    end
                                    default: begin
                                        if (idx == 4'd15) begin
                                            state  <= S_IDLE;
                                            busy_q <= 1'b0;
                                        end else begin
                                            idx        <= idx + 4'd1;
                                            lcd_data_q <= char_at(snap, idx + 4'd1);
                                        end
                                    end
                                endcase
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.lcd_e    = lcd_e_q;
    assign bus.lcd_rs   = lcd_rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = lcd_data_q;
endmodule

// File: tb/tb_lcd_string_writer.sv
// Directed bench for lcd_string_writer with short timing parameters; follows LCD_AUTO_REFRESH_EN if defined.
module tb_lcd_string_writer;
    logic clk;
    logic reset;
    int unsigned n_checks;
    int unsigned n_err;
    logic [8:0] cap[$];
    logic e_prev;

    lcd_string_writer_if bus();

    lcd_string_writer #(
        .INIT_WAIT (10),
        .E_PULSE   (2),
        .CMD_WAIT  (3),
        .CLEAR_WAIT(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record {rs, data} at every rising edge of lcd_e.
    initial e_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.lcd_e && !e_prev) cap.push_back({bus.lcd_rs, bus.lcd_data});
        e_prev <= bus.lcd_e;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int unsigned limit, output int unsigned n);
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (!bus.busy) break;
        end
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_update();
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
    endtask

    function automatic logic [8:0] exp_char(input logic [16*8:1] m, input int unsigned i);
        logic [7:0] c;
        c = m[8*(16-i) -: 8];
        if (c == 8'h00) c = 8'h20;
        return {1'b1, c};
    endfunction

    task automatic chk_refresh(input int unsigned off, input logic [16*8:1] m);
        chk("refresh_addr", 32'(cap[off]), 32'h080);
        for (int unsigned i = 0; i < 16; i++)
            chk("refresh_char", 32'(cap[off + 1 + i]), 32'(exp_char(m, i)));
    endtask

    task automatic run_init();
        int unsigned n;
        logic [8:0] init_exp[4];
        init_exp[0] = 9'h038;
        init_exp[1] = 9'h00C;
        init_exp[2] = 9'h006;
        init_exp[3] = 9'h001;
        cap.delete();
        reset = 1'b1;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (n == 10) begin
                chk("init_setup_data", 32'(bus.lcd_data), 32'h38);
                chk("init_setup_rs", 32'(bus.lcd_rs), 32'd0);
                chk("init_setup_e", 32'(bus.lcd_e), 32'd0);
            end
            if (n == 11) chk("init_pulse_rise", 32'(bus.lcd_e), 32'd1);
            if (n == 13) chk("init_pulse_fall", 32'(bus.lcd_e), 32'd0);
            if (!bus.busy) break;
        end
        chk("init_busy_fall_cycle", n, 32'd51);
        chk("init_byte_count", cap.size(), 32'd4);
        for (int unsigned i = 0; i < 4; i++)
            if (i < cap.size()) chk("init_byte", 32'(cap[i]), 32'(init_exp[i]));
    endtask

    // With auto-refresh the first string after init always triggers one refresh; let it finish.
    task automatic settle();
`ifdef LCD_AUTO_REFRESH_EN
        int unsigned n;
        step();
        wait_idle(300, n);
`endif
    endtask

    initial begin : stim
        logic [16*8:1] msg_win;
        logic [16*8:1] msg_lose;
        logic [16*8:1] msg_high;
        int unsigned n;
        n_checks = 0;
        n_err = 0;
        msg_win  = "YOU WIN! 7 TRIES";
        msg_lose = {96'h0, "LOSE"};
        msg_high = {"TOO HIGH", 64'h0};

        reset = 1'b0;
        bus.update = 1'b0;
        bus.str = msg_win;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_e", 32'(bus.lcd_e), 32'd0);
        chk("rst_rs", 32'(bus.lcd_rs), 32'd0);
        chk("rst_rw", 32'(bus.lcd_rw), 32'd0);
        chk("rst_data", 32'(bus.lcd_data), 32'h00);

        run_init();
        settle();

        // Single refresh of a full message.
        cap.delete();
        bus.str = msg_win;
        pulse_update();
        chk("win_start_busy", 32'(bus.busy), 32'd1);
        chk("win_start_data", 32'(bus.lcd_data), 32'h80);
        chk("win_start_e", 32'(bus.lcd_e), 32'd0);
        wait_idle(300, n);
        chk("win_busy_cycles", n, 32'd102);
        chk("win_byte_count", cap.size(), 32'd17);
        if (cap.size() >= 17) begin
            chk("win_first_char", 32'(cap[1]), 32'h159);
            chk_refresh(0, msg_win);
        end

        // Zero padding shows as spaces.
        cap.delete();
        bus.str = msg_lose;
        pulse_update();
        wait_idle(300, n);
        chk("lose_byte_count", cap.size(), 32'd17);
        if (cap.size() >= 17) begin
            for (int unsigned i = 1; i <= 12; i++)
                chk("lose_space", 32'(cap[i]), 32'h120);
            chk("lose_L", 32'(cap[13]), 32'h14C);
            chk("lose_O", 32'(cap[14]), 32'h14F);
            chk("lose_S", 32'(cap[15]), 32'h153);
            chk("lose_E", 32'(cap[16]), 32'h145);
        end

        // Requests while busy collapse to one; snapshot protects the running transfer.
        cap.delete();
        bus.str = msg_win;
        pulse_update();
        repeat (20) step();
        pulse_update();
        repeat (20) step();
        bus.str = msg_high;
        pulse_update();
        repeat (20) step();
        pulse_update();
        wait_idle(300, n);
        step();
        chk("pending_restart_busy", 32'(bus.busy), 32'd1);
        wait_idle(300, n);
        repeat (50) step();
        chk("pending_final_idle", 32'(bus.busy), 32'd0);
        chk("pending_byte_count", cap.size(), 32'd34);
        if (cap.size() >= 34) begin
            chk_refresh(0, msg_win);
            chk_refresh(17, msg_high);
            chk("high_T", 32'(cap[18]), 32'h154);
            chk("high_pad", 32'(cap[33]), 32'h120);
        end

        // Reset in the middle of a CHAR pulse.
        cap.delete();
        bus.str = msg_lose;
        pulse_update();
        n = 0;
        while (n < 200 && !(cap.size() >= 5 && bus.lcd_e)) begin
            step();
            n++;
        end
        chk("midreset_found_pulse", 32'(bus.lcd_e), 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_e", 32'(bus.lcd_e), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd1);
        chk("midreset_data", 32'(bus.lcd_data), 32'h00);
        step();
        run_init();
        settle();

`ifdef LCD_AUTO_REFRESH_EN
        cap.delete();
        bus.str = msg_win;
        step();
        chk("auto_start_busy", 32'(bus.busy), 32'd1);
        chk("auto_start_data", 32'(bus.lcd_data), 32'h80);
        wait_idle(300, n);
        chk("auto_busy_cycles", n, 32'd102);
        repeat (60) step();
        chk("auto_no_repeat", 32'(bus.busy), 32'd0);
        chk("auto_byte_count", cap.size(), 32'd17);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
